seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. Scans one digit per refresh slot with correct wrap at N_DIGITS, double-buffers the displayed value so updates land only on frame boundaries (no tearing), and adds leading-zero blanking, per-digit blink, per-digit decimal point and PWM brightness. It sits between the BCD conversion logic and the board display pins.

## Interface
- N_DIGITS, 12: number of digits scanned; 2..16.
- DIV_LOG2, 17: log2 of clk cycles per digit slot.
- BR_W, 3: brightness control width.
- BLINK_LOG2, 5: log2 of frames per blink half-period.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = show active value; 0 = every digit shows "-" (glyph 4'hA), dp off; scanning continues.
- load  in  1  single-cycle strobe capturing digits, dp_mask, blink_mask into the shadow register.
- digits  in  4*N_DIGITS  glyph codes; digit 0 = bits [3:0] = least significant / rightmost.
- dp_mask  in  N_DIGITS  1 = decimal point lit on that digit.
- blink_mask  in  N_DIGITS  1 = digit blinks.
- blank_lz  in  1  1 = leading-zero blanking enabled (level, applied live).
- brightness  in  BR_W  PWM level; all-ones = full on.
- seg  out  7  segments {g,f,e,d,c,b,a}, 1 = lit.
- dp  out  1  decimal point, 1 = lit.
- anode  out  N_DIGITS  one-hot digit enable, 1 = digit on; all-zero during PWM off-time.
- frame_start  out  1  one-cycle pulse when digit 0 slot begins.
- load_ack  out  1  one-cycle pulse when shadow is committed to the active register.

## Operation
- Glyph codes: 0-9 digits, 4'hA "-", 4'hB..4'hE per shared glyph table, 4'hF blank.
- Prescaler cnt: DIV_LOG2-bit free-running; tick when cnt all ones.
- Digit index idx: advances on tick; N_DIGITS-1 wraps to 0 (never visits idx >= N_DIGITS). Wrap = frame end.
- Load: on load, shadow <= inputs, pending <= 1. On frame end with pending, active <= shadow (value held at start of that cycle), pending <= 0, load_ack pulses. load on the commit cycle: shadow takes the new data, pending stays 1, committed next frame. Multiple loads in a frame: last wins.
- Leading-zero blanking (blank_lz=1): scanning from digit N_DIGITS-1 downward, code-0 digits blank until the first nonzero code; digit 0 never blanked; dp on a blanked digit still shown.
- Blink: frame counter of BLINK_LOG2 bits; blink_phase toggles when it wraps. Digits with blink_mask set are blank (seg=0, dp=0, anode still driven) while blink_phase=1.
- PWM: phase = cnt[DIV_LOG2-1 -: BR_W]; anode asserted only while phase <= brightness. brightness=0 gives 1/2^BR_W duty.
- Precedence per digit: en=0 -> "-"; else blink blank; else leading-zero blank; else glyph.

## Timing
- Outputs registered: seg/dp/anode reflect idx/cnt of the previous cycle (1-cycle latency).
- frame_start asserted the cycle anode[0] first goes active for the new frame.
- load_ack coincides with the cycle after the commit edge; new value visible starting on digit 0 of that frame.
- Reset values: cnt=0, idx=0, blink counter/phase=0, pending=0, shadow/active digits=all 4'hF, masks=0; outputs seg=0, dp=0, anode=0, frame_start=0, load_ack=0. First anode[0] active the cycle after rst deasserts.
- Reset mid-frame discards pending load; no load_ack generated.

## Structure
- Shared package/header: glyph code constants (GLYPH_DASH=4'hA, GLYPH_BLANK=4'hF) and the 16-entry segment table.
- One sub-module: seg7_glyph_rom (4-bit code -> 7 segments, combinational).
- Top: prescaler, idx counter, shadow/active registers, blink counter, LZ logic, output registers.

## Test plan
- N_DIGITS=6, DIV_LOG2=3: after reset anode cycles 000001..100000 each 8 cycles, wraps to 000001, never all-zero at brightness max.
- load digits=0x000123 mid-frame -> display unchanged until wrap; load_ack once; blank_lz=1 shows digits 5..3 blank, "123".
- Two loads in one frame (0x111111 then 0x222222) -> only 0x222222 committed, single load_ack.
- load on exact commit cycle -> old shadow committed, new value committed next frame, two load_acks.
- blink_mask=6'b000001, BLINK_LOG2=1 -> digit 0 lit 2 frames, blank 2 frames; others steady.
- BR_W=3, brightness=3 -> anode high 4 of 8 cycles per slot; en=0 -> all digits seg = dash pattern, dp=0.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// Shared glyph codes and the 16-entry segment table for the seven-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, 1 = lit.
package seven_segment_scanner_pkg;

  typedef logic [3:0] glyph_t;
  typedef logic [6:0] seg_t;

  localparam glyph_t GLYPH_DASH  = 4'hA;
  localparam glyph_t GLYPH_BLANK = 4'hF;

  // Packed table, index 15 at the MSB end: B="H", C="L", D="P", E="E".
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h00,  // F blank
    7'h79,  // E
    7'h73,  // D
    7'h38,  // C
    7'h76,  // B
    7'h40,  // A dash
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Control/display bundle between the BCD logic (master) and the scanner (slave).
// Display pin outputs are driven by the slave side.
interface seven_segment_scanner_if
  import seven_segment_scanner_pkg::*;
#(
  parameter int N_DIGITS = 12,
  parameter int BR_W     = 3
);
  logic                  en;
  logic                  load;
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [N_DIGITS-1:0]   blink_mask;
  logic                  blank_lz;
  logic [BR_W-1:0]       brightness;
  seg_t                  seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   anode;
  logic                  frame_start;
  logic                  load_ack;

  modport master (
    output en, load, digits, dp_mask, blink_mask, blank_lz, brightness,
    input  seg, dp, anode, frame_start, load_ack
  );

  modport slave (
    input  en, load, digits, dp_mask, blink_mask, blank_lz, brightness,
    output seg, dp, anode, frame_start, load_ack
  );
endinterface

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph-code to segment lookup from the shared table.
module seg7_glyph_rom
  import seven_segment_scanner_pkg::*;
(
  input  glyph_t i_code,
  output seg_t   o_seg
);
  assign o_seg = SEG_TABLE[i_code];
endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit scanner: double-buffered value committed at frame wrap,
// leading-zero blanking, blink, decimal points and PWM; outputs registered one cycle.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int N_DIGITS   = 12,
  parameter int DIV_LOG2   = 17,
  parameter int BR_W       = 3,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  seven_segment_scanner_if.slave bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [DIV_LOG2-1:0]   r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BLINK_LOG2-1:0] r_blink_cnt;
  logic                  r_blink_phase;

  logic [4*N_DIGITS-1:0] r_shadow_digits;
  logic [N_DIGITS-1:0]   r_shadow_dp;
  logic [N_DIGITS-1:0]   r_shadow_blink;
  logic [4*N_DIGITS-1:0] r_active_digits;
  logic [N_DIGITS-1:0]   r_active_dp;
  logic [N_DIGITS-1:0]   r_active_blink;
  logic                  r_pending;

  seg_t                  r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_anode;
  logic                  r_frame_start;
  logic                  r_load_ack;

  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_commit;
  logic [N_DIGITS-1:0]   w_lz_mask;
  glyph_t                w_code;
  logic                  w_dp;
  seg_t                  w_seg;
  logic                  w_pwm_on;

  assign w_tick      = &r_cnt;
  assign w_frame_end = w_tick && (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_commit    = w_frame_end && r_pending;
  assign w_pwm_on    = (r_cnt[DIV_LOG2-1 -: BR_W] <= bus.brightness);

  always_ff @(posedge i_clk) begin : scan_counters
    if (i_rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_cnt <= r_cnt + DIV_LOG2'(1);
      if (w_tick) begin
        r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
      end
      if (w_frame_end) begin
        r_blink_cnt <= r_blink_cnt + BLINK_LOG2'(1);
        if (&r_blink_cnt) begin
          r_blink_phase <= ~r_blink_phase;
        end
      end
    end
  end

  // Commit copies the shadow as it was before this edge; a coincident load refills the shadow.
  always_ff @(posedge i_clk) begin : double_buffer
    if (i_rst) begin
      r_shadow_digits <= {N_DIGITS{GLYPH_BLANK}};
      r_shadow_dp     <= '0;
      r_shadow_blink  <= '0;
      r_active_digits <= {N_DIGITS{GLYPH_BLANK}};
      r_active_dp     <= '0;
      r_active_blink  <= '0;
      r_pending       <= 1'b0;
    end else begin
      if (w_commit) begin
        r_active_digits <= r_shadow_digits;
        r_active_dp     <= r_shadow_dp;
        r_active_blink  <= r_shadow_blink;
      end
      if (bus.load) begin
        r_shadow_digits <= bus.digits;
        r_shadow_dp     <= bus.dp_mask;
        r_shadow_blink  <= bus.blink_mask;
        r_pending       <= 1'b1;
      end else if (w_commit) begin
        r_pending       <= 1'b0;
      end
    end
  end

  // Digit i is a leading zero when it and every more-significant digit hold code 0.
  always_comb begin : lz_scan
    logic v_run;
    v_run     = 1'b1;
    w_lz_mask = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      v_run        = v_run && (r_active_digits[4*i +: 4] == 4'h0);
      w_lz_mask[i] = v_run;
    end
  end

  always_comb begin : glyph_select
    w_code = r_active_digits[4*r_idx +: 4];
    w_dp   = r_active_dp[r_idx];
    if (!bus.en) begin
      w_code = GLYPH_DASH;
      w_dp   = 1'b0;
    end else if (r_active_blink[r_idx] && r_blink_phase) begin
      w_code = GLYPH_BLANK;
      w_dp   = 1'b0;
    end else if (bus.blank_lz && w_lz_mask[r_idx]) begin
      w_code = GLYPH_BLANK;
    end
  end

  seg7_glyph_rom u_glyph_rom (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  always_ff @(posedge i_clk) begin : output_regs
    if (i_rst) begin
      r_seg         <= '0;
      r_dp          <= 1'b0;
      r_anode       <= '0;
      r_frame_start <= 1'b0;
      r_load_ack    <= 1'b0;
    end else begin
      r_seg         <= w_seg;
      r_dp          <= w_dp;
      r_anode       <= w_pwm_on ? (N_DIGITS'(1) << r_idx) : '0;
      r_frame_start <= (r_idx == '0) && (r_cnt == '0);
      r_load_ack    <= w_commit;
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.anode       = r_anode;
  assign bus.frame_start = r_frame_start;
  assign bus.load_ack    = r_load_ack;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: per-cycle reference model from time arithmetic,
// a glyph vector table, and directed multi-cycle sequences plus random stimulus.
module tb_seven_segment_scanner;
  localparam int ND    = 6;
  localparam int DL    = 3;
  localparam int BW    = 3;
  localparam int BL    = 1;
  localparam int SLOT  = 1 << DL;
  localparam int FRAME = ND * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_scanner_if #(.N_DIGITS(ND), .BR_W(BW)) bus();

  seven_segment_scanner #(
    .N_DIGITS(ND), .DIV_LOG2(DL), .BR_W(BW), .BLINK_LOG2(BL)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h76, 7'h38, 7'h73, 7'h79, 7'h00};

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  // Reference state: m_s = clock edges since reset released.
  int             m_s;
  logic [4*ND-1:0] m_sh_d, m_act_d;
  logic [ND-1:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
  logic           m_pend;
  logic [6:0]     e_seg;
  logic           e_dp, e_fs, e_ack;
  logic [ND-1:0]  e_an;

  int acks, obs_an_on, obs_d0_blank, obs_dash;

  typedef struct {
    logic [3:0] code;
    logic       dp;
    logic       lz;
    logic [6:0] exp_seg;
    logic       exp_dp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clr_obs();
    acks = 0; obs_an_on = 0; obs_d0_blank = 0; obs_dash = 0;
  endtask

  task automatic cyc();
    int cnt, idx, frame;
    logic [3:0] code;
    @(posedge clk);
    if (rst) begin
      e_seg = '0; e_dp = 1'b0; e_an = '0; e_fs = 1'b0; e_ack = 1'b0;
      m_s = 0; m_pend = 1'b0;
      m_sh_d = {ND{4'hF}}; m_act_d = {ND{4'hF}};
      m_sh_dp = '0; m_act_dp = '0; m_sh_bl = '0; m_act_bl = '0;
    end else begin
      cnt   = m_s % SLOT;
      idx   = (m_s / SLOT) % ND;
      frame = m_s / FRAME;
      code  = m_act_d[4*idx +: 4];
      e_seg = seg_tab[code];
      e_dp  = m_act_dp[idx];
      if (!bus.en) begin
        e_seg = 7'h40; e_dp = 1'b0;
      end else if (m_act_bl[idx] && ((frame >> BL) % 2 == 1)) begin
        e_seg = '0; e_dp = 1'b0;
      end else if (bus.blank_lz && idx > 0 && (m_act_d >> (4*idx)) == 0) begin
        e_seg = '0;
      end
      e_an  = ((cnt >> (DL - BW)) <= int'(bus.brightness)) ? (ND'(1) << idx) : '0;
      e_fs  = (m_s % FRAME == 0);
      e_ack = (m_s % FRAME == FRAME - 1) && m_pend;
      if (e_ack) begin
        m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl; m_pend = 1'b0;
      end
      if (bus.load) begin
        m_sh_d = bus.digits; m_sh_dp = bus.dp_mask; m_sh_bl = bus.blink_mask; m_pend = 1'b1;
      end
      m_s++;
    end
    @(negedge clk);
    cyc_no++;
    checks++;
    if (bus.seg !== e_seg || bus.dp !== e_dp || bus.anode !== e_an ||
        bus.frame_start !== e_fs || bus.load_ack !== e_ack) begin
      errors++;
      $display("FAIL model cyc=%0d got seg=%h dp=%b an=%b fs=%b ack=%b expected seg=%h dp=%b an=%b fs=%b ack=%b",
               cyc_no, bus.seg, bus.dp, bus.anode, bus.frame_start, bus.load_ack,
               e_seg, e_dp, e_an, e_fs, e_ack);
    end
    acks         += int'(bus.load_ack);
    obs_an_on    += int'(bus.anode != '0);
    obs_d0_blank += int'(bus.anode[0] && bus.seg == 7'h00);
    obs_dash     += int'(bus.seg == 7'h40 && !bus.dp);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.frame_start && n < 2 * FRAME);
    if (!bus.frame_start) begin
      checks++; errors++;
      $display("FAIL frame_start_timeout got 0 expected 1 within %0d cycles", 2 * FRAME);
    end
  endtask

  task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] dpm, input logic [ND-1:0] blm);
    bus.digits = d; bus.dp_mask = dpm; bus.blink_mask = blm; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'h0, 1'b1, 1'b0, 7'h3F, 1'b1};
    vecs[1] = '{4'h5, 1'b0, 1'b0, 7'h6D, 1'b0};
    vecs[2] = '{4'h8, 1'b1, 1'b0, 7'h7F, 1'b1};
    vecs[3] = '{4'h9, 1'b0, 1'b0, 7'h6F, 1'b0};
    vecs[4] = '{4'hA, 1'b0, 1'b0, 7'h40, 1'b0};
    vecs[5] = '{4'hC, 1'b1, 1'b0, 7'h38, 1'b1};
    vecs[6] = '{4'hF, 1'b1, 1'b0, 7'h00, 1'b1};
    vecs[7] = '{4'h0, 1'b0, 1'b1, 7'h3F, 1'b0};

    bus.en = 1'b1; bus.load = 1'b0; bus.digits = '0; bus.dp_mask = '0;
    bus.blink_mask = '0; bus.blank_lz = 1'b0; bus.brightness = '1;
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_anode", int'(bus.anode), 0);
    chk("reset_seg", int'(bus.seg), 0);
    rst = 1'b0;
    cyc();
    chk("first_anode", int'(bus.anode), 1);
    chk("first_frame_start", int'(bus.frame_start), 1);

    clr_obs();
    repeat (2 * FRAME) cyc();
    chk("scan_anode_never_zero", obs_an_on, 2 * FRAME);

    foreach (vecs[i]) begin
      bus.blank_lz = vecs[i].lz;
      wait_fs();
      repeat (3) cyc();
      do_load({ND{vecs[i].code}}, {{(ND-1){1'b0}}, vecs[i].dp}, '0);
      wait_fs();
      chk($sformatf("glyph_seg_%0d", i), int'(bus.seg), int'(vecs[i].exp_seg));
      chk($sformatf("glyph_dp_%0d", i), int'(bus.dp), int'(vecs[i].exp_dp));
    end

    // 0x000123 with leading-zero blanking
    bus.blank_lz = 1'b1;
    wait_fs();
    repeat (10) cyc();
    clr_obs();
    do_load(24'h000123, '0, '0);
    repeat (FRAME) cyc();
    chk("lz_load_ack_count", acks, 1);
    wait_fs();
    chk("lz_digit0", int'(bus.seg), 7'h4F);
    repeat (5 * SLOT) cyc();
    chk("lz_digit5_anode", int'(bus.anode), 6'b100000);
    chk("lz_digit5_blank", int'(bus.seg), 0);

    // two loads in one frame: last wins
    bus.blank_lz = 1'b0;
    wait_fs();
    repeat (3) cyc();
    clr_obs();
    do_load(24'h111111, '0, '0);
    repeat (5) cyc();
    do_load(24'h222222, '0, '0);
    repeat (FRAME) cyc();
    chk("double_load_ack_count", acks, 1);
    wait_fs();
    chk("double_load_value", int'(bus.seg), 7'h5B);

    // load on the exact commit cycle
    wait_fs();
    repeat (5) cyc();
    do_load(24'h444444, '0, '0);
    while (m_s % FRAME != FRAME - 1) cyc();
    clr_obs();
    do_load(24'h555555, '0, '0);
    wait_fs();
    chk("commit_edge_old_value", int'(bus.seg), 7'h66);
    repeat (FRAME) cyc();
    chk("commit_edge_ack_count", acks, 2);
    wait_fs();
    chk("commit_edge_new_value", int'(bus.seg), 7'h6D);

    // blink digit 0
    wait_fs();
    repeat (2) cyc();
    do_load(24'h000003, '0, 6'b000001);
    wait_fs();
    clr_obs();
    repeat (4 * FRAME) cyc();
    chk("blink_d0_blank_cycles", obs_d0_blank, 2 * SLOT);

    bus.brightness = 3'd3;
    clr_obs();
    repeat (FRAME) cyc();
    chk("pwm_on_cycles", obs_an_on, ND * 4);
    bus.brightness = '1;

    bus.en = 1'b0;
    clr_obs();
    repeat (FRAME) cyc();
    chk("disable_dash_cycles", obs_dash, FRAME);
    bus.en = 1'b1;

    // reset with a pending load discards it
    wait_fs();
    repeat (4) cyc();
    do_load(24'h999999, '1, '0);
    repeat (4) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    clr_obs();
    repeat (2 * FRAME) cyc();
    chk("reset_discard_ack_count", acks, 0);

    for (int n = 0; n < 3000; n++) begin
      bus.load = ($urandom_range(0, 39) == 0);
      bus.digits = 24'($urandom) >> (4 * $urandom_range(0, 6));
      bus.dp_mask = 6'($urandom);
      bus.blink_mask = 6'($urandom);
      bus.en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(0, 199) == 0) bus.brightness = 3'($urandom);
      rst = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    rst = 1'b0;
    bus.load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
